display_counter: RTL and testbench



---
 rtl/display_counter_pkg.sv | 15 +
 rtl/digit_cell.sv | 42 ++++
 rtl/display_counter.sv | 79 +++++++
 tb/tb_display_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/display_counter_pkg.sv
// Shared digit type and helpers for the multi-digit display counter.
package display_counter_pkg;

    localparam int DIGIT_BITS = 4;

    typedef logic [DIGIT_BITS-1:0] digit_t;

    // Loaded digits outside the radix are pulled down to the largest legal digit.
    function automatic digit_t clamp_digit(digit_t d, int unsigned base);
        if ({28'd0, d} >= base)
            return digit_t'(base - 1);
        return d;
    endfunction

endpackage

// File: rtl/digit_cell.sv
// One radix-BASE digit: register, load with clamp, and a single inc/dec step.
module digit_cell
    import display_counter_pkg::*;
#(
    parameter int BASE = 10
) (
    input  logic   slow_clk,
    input  logic   rst,
    input  logic   load_i,
    input  digit_t load_val_i,
    input  logic   step_i,
    input  logic   down_i,
    output digit_t digit_o,
    output logic   carry_o
);

    localparam digit_t MAX_D = digit_t'(BASE - 1);

    digit_t digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = clamp_digit(load_val_i, BASE);
        end else if (step_i) begin
            if (down_i)
                digit_d = (digit_q == '0) ? MAX_D : digit_q - 4'd1;
            else
                digit_d = (digit_q == MAX_D) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) digit_q <= '0;
        else     digit_q <= digit_d;
    end

    // Carry/borrow passes upward only when this digit rolls over on this step.
    assign carry_o = step_i & (down_i ? (digit_q == '0) : (digit_q == MAX_D));
    assign digit_o = digit_q;

endmodule

// File: rtl/display_counter.sv
// Multi-digit up/down display counter with load, wrap/saturate, and blanking mask.
module display_counter #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_BITS = 4,
    parameter int BASE       = 10
) (
    input  logic                             slow_clk,
    input  logic                             rst,
    input  logic                             in_enable,
    input  logic                             in_down,
    input  logic                             in_saturate,
    input  logic                             in_load,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_load_value,
    output logic [NUM_DIGITS*DIGIT_BITS-1:0] out_digits,
    output logic [NUM_DIGITS-1:0]            out_blank,
    output logic                             out_wrap,
    output logic                             out_at_max,
    output logic                             out_at_zero
);
    import display_counter_pkg::*;

    localparam digit_t MAX_D = digit_t'(BASE - 1);

    logic [NUM_DIGITS-1:0][DIGIT_BITS-1:0] digits;
    logic [NUM_DIGITS:0]                   step;
    logic                                  at_bound;
    logic                                  wrap_q, wrap_d;

    // A saturating step at the bound is suppressed at its source so nothing ripples.
    assign at_bound = in_down ? out_at_zero : out_at_max;
    assign step[0]  = in_enable & ~in_load & ~(in_saturate & at_bound);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_cell
        digit_cell #(.BASE(BASE)) u_cell (
            .slow_clk   (slow_clk),
            .rst        (rst),
            .load_i     (in_load),
            .load_val_i (in_load_value[i*DIGIT_BITS +: DIGIT_BITS]),
            .step_i     (step[i]),
            .down_i     (in_down),
            .digit_o    (digits[i]),
            .carry_o    (step[i+1])
        );
    end

    assign out_digits = digits;

    always_comb begin
        out_at_max  = 1'b1;
        out_at_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digits[i] != MAX_D) out_at_max  = 1'b0;
            if (digits[i] != '0)    out_at_zero = 1'b0;
        end
    end

    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        out_blank  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above   = zero_above & (digits[i] == '0);
            out_blank[i] = zero_above;
        end
        // The ones digit is always shown, even for a zero count.
        out_blank[0] = 1'b0;
    end

    // A carry out of the top digit means the whole count rolled over.
    assign wrap_d = step[NUM_DIGITS];

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) wrap_q <= 1'b0;
        else     wrap_q <= wrap_d;
    end

    assign out_wrap = wrap_q;

endmodule

// File: tb/tb_display_counter.sv
// Bench for display_counter: vector table, hand sequences, and randomized model check.
module tb_display_counter;

    localparam int N = 4;
    localparam int B = 10;

    logic        slow_clk = 1'b0;
    logic        rst      = 1'b1;
    logic        en = 0, dn = 0, sat = 0, ld = 0;
    logic [15:0] ldv = '0;
    logic [15:0] dig;
    logic [3:0]  blank;
    logic        wrap, at_max, at_zero;

    logic        en16 = 0, ld16 = 0;
    logic [15:0] ldv16 = '0;
    logic [15:0] dig16;
    logic [3:0]  blank16;
    logic        wrap16, at_max16, at_zero16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 slow_clk = ~slow_clk;

    display_counter #(.NUM_DIGITS(N), .DIGIT_BITS(4), .BASE(B)) dut (
        .slow_clk(slow_clk), .rst(rst), .in_enable(en), .in_down(dn),
        .in_saturate(sat), .in_load(ld), .in_load_value(ldv),
        .out_digits(dig), .out_blank(blank), .out_wrap(wrap),
        .out_at_max(at_max), .out_at_zero(at_zero)
    );

    display_counter #(.NUM_DIGITS(N), .DIGIT_BITS(4), .BASE(16)) dut16 (
        .slow_clk(slow_clk), .rst(rst), .in_enable(en16), .in_down(dn),
        .in_saturate(sat), .in_load(ld16), .in_load_value(ldv16),
        .out_digits(dig16), .out_blank(blank16), .out_wrap(wrap16),
        .out_at_max(at_max16), .out_at_zero(at_zero16)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
    endtask

    // Reference model: the count is an integer in [0, B^N - 1].
    function automatic int pow_b(int b, int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    function automatic int to_val(logic [15:0] p, int b);
        int v = 0;
        for (int i = N - 1; i >= 0; i--) begin
            int d = int'(p[i*4 +: 4]);
            if (d > b - 1) d = b - 1;
            v = v * b + d;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_pk(int v, int b);
        logic [15:0] p = '0;
        for (int i = 0; i < N; i++) begin
            p[i*4 +: 4] = 4'(v % b);
            v = v / b;
        end
        return p;
    endfunction

    function automatic logic [3:0] blank_of(int v, int b);
        logic [3:0] m = '0;
        for (int i = 1; i < N; i++) m[i] = (v < pow_b(b, i));
        return m;
    endfunction

    int mv    = 0;
    bit mwrap = 0;

    task automatic model_edge(logic l, logic [15:0] lv, logic e, logic d, logic s);
        int maxv = pow_b(B, N) - 1;
        mwrap = 0;
        if (l) mv = to_val(lv, B);
        else if (e) begin
            if (!d) begin
                if (mv == maxv) begin
                    if (!s) begin mv = 0; mwrap = 1; end
                end else mv++;
            end else begin
                if (mv == 0) begin
                    if (!s) begin mv = maxv; mwrap = 1; end
                end else mv--;
            end
        end
    endtask

    typedef struct {
        logic        l;
        logic [15:0] lv;
        logic        e, d, s;
        logic [15:0] exp_d;
        logic        exp_w;
        logic [3:0]  exp_b;
    } vec_t;

    vec_t tv[16];

    initial begin
        tv[0]  = '{1, 16'h0099, 0, 0, 0, 16'h0099, 0, 4'b1100};
        tv[1]  = '{0, 16'h0000, 1, 0, 0, 16'h0100, 0, 4'b1000};
        tv[2]  = '{1, 16'h9999, 0, 0, 0, 16'h9999, 0, 4'b0000};
        tv[3]  = '{0, 16'h0000, 1, 0, 0, 16'h0000, 1, 4'b1110};
        tv[4]  = '{0, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b1110};
        tv[5]  = '{1, 16'h9999, 0, 0, 0, 16'h9999, 0, 4'b0000};
        tv[6]  = '{0, 16'h0000, 1, 0, 1, 16'h9999, 0, 4'b0000};
        tv[7]  = '{0, 16'h0000, 1, 1, 0, 16'h9998, 0, 4'b0000};
        tv[8]  = '{1, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b1110};
        tv[9]  = '{0, 16'h0000, 1, 1, 0, 16'h9999, 1, 4'b0000};
        tv[10] = '{1, 16'h0000, 0, 0, 0, 16'h0000, 0, 4'b1110};
        tv[11] = '{0, 16'h0000, 1, 1, 1, 16'h0000, 0, 4'b1110};
        tv[12] = '{1, 16'h12AF, 1, 0, 0, 16'h1299, 0, 4'b0000};
        tv[13] = '{0, 16'h0000, 1, 1, 0, 16'h1298, 0, 4'b0000};
        tv[14] = '{1, 16'h0009, 0, 0, 0, 16'h0009, 0, 4'b1110};
        tv[15] = '{0, 16'h0000, 1, 0, 0, 16'h0010, 0, 4'b1100};

        // Reset state, held across a few edges
        #22;
        check("rst_digits", 32'(dig), 32'h0000);
        check("rst_blank", 32'(blank), 32'b1110);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_at_zero", 32'(at_zero), 1);
        check("rst_at_max", 32'(at_max), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            ld = tv[i].l; ldv = tv[i].lv; en = tv[i].e; dn = tv[i].d; sat = tv[i].s;
            tick();
            check($sformatf("vec%0d_digits", i), 32'(dig), 32'(tv[i].exp_d));
            check($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tv[i].exp_w));
            check($sformatf("vec%0d_blank", i), 32'(blank), 32'(tv[i].exp_b));
            check($sformatf("vec%0d_at_max", i), 32'(at_max), 32'(tv[i].exp_d == 16'h9999));
            check($sformatf("vec%0d_at_zero", i), 32'(at_zero), 32'(tv[i].exp_d == 16'h0000));
        end
        ld = 0; en = 0;

        // Asynchronous reset mid-cycle while enabled
        ld = 1; ldv = 16'h0123; tick();
        ld = 0; en = 1; dn = 0; sat = 0;
        #3 rst = 1'b1;
        #1;
        check("async_rst_digits", 32'(dig), 32'h0000);
        check("async_rst_blank", 32'(blank), 32'b1110);
        check("async_rst_at_zero", 32'(at_zero), 1);
        tick();
        check("rst_hold_digits", 32'(dig), 32'h0000);
        #2 rst = 1'b0;
        tick();
        check("first_count_after_rst", 32'(dig), 32'h0001);
        en = 0;

        // Randomized traffic against the integer model
        ld = 1; ldv = 16'h0000; model_edge(1, 16'h0000, 0, 0, 0); tick();
        for (int k = 0; k < 400; k++) begin
            int sel;
            ld  = ($urandom_range(0, 9) == 0);
            sel = $urandom_range(0, 3);
            ldv = (sel == 0) ? 16'h9999 : (sel == 1) ? 16'h0000 :
                  (sel == 2) ? 16'h9990 : 16'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            dn  = 1'($urandom);
            sat = 1'($urandom);
            model_edge(ld, ldv, en, dn, sat);
            tick();
            check("rnd_digits", 32'(dig), 32'(to_pk(mv, B)));
            check("rnd_wrap", 32'(wrap), 32'(mwrap));
            check("rnd_blank", 32'(blank), 32'(blank_of(mv, B)));
            check("rnd_at_max", 32'(at_max), 32'(mv == pow_b(B, N) - 1));
            check("rnd_at_zero", 32'(at_zero), 32'(mv == 0));
        end
        ld = 0; en = 0; dn = 0; sat = 0;

        // Hex base: carry across two full digits, then full wrap
        ld16 = 1; ldv16 = 16'h00FF; tick();
        ld16 = 0; en16 = 1; tick();
        en16 = 0;
        check("hex_carry_digits", 32'(dig16), 32'h0100);
        check("hex_carry_blank", 32'(blank16), 32'b1000);
        ld16 = 1; ldv16 = 16'hFFFF; tick();
        check("hex_at_max", 32'(at_max16), 1);
        ld16 = 0; en16 = 1; tick();
        en16 = 0;
        check("hex_wrap_digits", 32'(dig16), 32'h0000);
        check("hex_wrap_pulse", 32'(wrap16), 1);
        check("hex_wrap_at_zero", 32'(at_zero16), 1);
        tick();
        check("hex_wrap_pulse_end", 32'(wrap16), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
